// File: rtl/rs485_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : rs485_tx_buffered
// Purpose  : FIFO-buffered 8N1 UART transmitter with RS-485 driver enable,
//            clocked at 16x baud. Optional even parity via TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rs485_tx_buffered #(
    parameter int FIFO_DEPTH = 16,
    parameter int DE_LEAD    = 16,
    parameter int DE_TAIL    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] datain,
    input  logic       wrsig,
    output logic       full,
    output logic       overflow,
    output logic       tx,
    output logic       de,
    output logic       idle
);
    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int WAIT_MAX = (DE_LEAD > DE_TAIL) ? DE_LEAD : DE_TAIL;
    localparam int WW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [PW:0]   CNT_FULL  = (PW+1)'(FIFO_DEPTH);
    localparam logic [WW-1:0] LEAD_LAST = WW'(DE_LEAD - 1);
    localparam logic [WW-1:0] TAIL_LAST = WW'(DE_TAIL - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd5,
        S_TAIL   = 3'd6
    } state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_count;
    state_t        r_state, w_state_next;
    logic [3:0]    r_tick;
    logic [2:0]    r_bit, w_bit_next;
    logic [WW-1:0] r_wait, w_wait_next;
    logic [7:0]    r_shift;
`ifdef TX_PARITY_EN
    logic          r_parity;
`endif
    logic          w_push, w_load, w_shift_adv, w_tx_next, w_empty, w_tick_last, w_in_frame;
    logic [PW:0]   w_count_next;

    assign w_push       = wrsig && !full;
    assign w_empty      = (r_count == '0);
    assign w_tick_last  = (r_tick == 4'hF);
    assign w_count_next = r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_load};
    assign w_in_frame   = (r_state == S_START) || (r_state == S_DATA) ||
`ifdef TX_PARITY_EN
                          (r_state == S_PARITY) ||
`endif
                          (r_state == S_STOP);

    // The head is claimed as soon as a burst is committed, so the slot frees
    // during the lead time rather than at the first start bit.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        w_bit_next   = r_bit;
        w_load       = 1'b0;
        w_shift_adv  = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_load       = 1'b1;
                    w_wait_next  = '0;
                    w_state_next = (DE_LEAD == 0) ? S_START : S_LEAD;
                end
            end
            S_LEAD: begin
                if (r_wait == LEAD_LAST) w_state_next = S_START;
                else                     w_wait_next  = r_wait + WW'(1);
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_tick_last) begin
                    w_state_next = S_DATA;
                    w_bit_next   = 3'd0;
                end
            end
            S_DATA: begin
                w_tx_next = r_shift[0];
                if (w_tick_last) begin
                    w_shift_adv = 1'b1;
                    if (r_bit == 3'd7) begin
`ifdef TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY: begin
                w_tx_next = r_parity;
                if (w_tick_last) w_state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tick_last) begin
                    w_wait_next = '0;
                    if (!w_empty) begin
                        w_load       = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = (DE_TAIL == 0) ? S_IDLE : S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (!w_empty) begin
                    w_load       = 1'b1;
                    w_state_next = S_START;
                end else if (r_wait == TAIL_LAST) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_wait_next = r_wait + WW'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= datain;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= S_IDLE;
            r_tick   <= 4'd0;
            r_bit    <= 3'd0;
            r_wait   <= '0;
            r_shift  <= 8'd0;
`ifdef TX_PARITY_EN
            r_parity <= 1'b0;
`endif
            full     <= 1'b0;
            overflow <= 1'b0;
            tx       <= 1'b1;
            de       <= 1'b0;
            idle     <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_load) begin
                r_shift  <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PW'(1);
`ifdef TX_PARITY_EN
                r_parity <= ^r_mem[r_rd_ptr];
`endif
            end else if (w_shift_adv) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
            r_count  <= w_count_next;
            full     <= (w_count_next == CNT_FULL);
            overflow <= wrsig && full;
            r_state  <= w_state_next;
            r_wait   <= w_wait_next;
            r_bit    <= w_bit_next;
            r_tick   <= w_in_frame ? r_tick + 4'd1 : 4'd0;
            tx       <= w_tx_next;
            de       <= (r_state != S_IDLE);
            idle     <= (w_count_next == '0) && (w_state_next == S_IDLE) && (r_state == S_IDLE);
        end
    end
endmodule
`default_nettype wire
